alu_exec_unit: RTL and testbench

Execution unit that consumes the 3-bit ALU control code produced by the ALU control decoder and performs the selected operation on two register operands. Add, subtract, AND, OR and set-less-than complete in one cycle. Multiply runs as a WIDTH-cycle radix-2 shift-add sequence with a busy/done handshake, so the datapath's control FSM stalls on it. It sits in the EX stage between the register file/immediate mux and the writeback mux.

---
 rtl/alu_exec_unit_if.sv | 23 ++
 rtl/alu_exec_unit.sv | 96 +++++++++
 tb/tb_alu_exec_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Request/result bundle between the EX-stage controller and alu_exec_unit.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, ALUCtrl_i, data1_i, data2_i,
    input  data_o, zero_o, busy_o, done_o
  );

  modport slave (
    input  start_i, ALUCtrl_i, data1_i, data2_i,
    output data_o, zero_o, busy_o, done_o
  );
endinterface

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle AND/OR/ADD/SUB/SLT plus a WIDTH-cycle shift-add
// multiply with busy/done handshake.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  alu_exec_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] alu_res;

  always_comb begin
    alu_res = '0;
    unique case (bus.ALUCtrl_i)
      OP_AND: alu_res = bus.data1_i & bus.data2_i;
      OP_OR:  alu_res = bus.data1_i | bus.data2_i;
      OP_ADD: alu_res = bus.data1_i + bus.data2_i;
      OP_SUB: alu_res = bus.data1_i - bus.data2_i;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.data1_i) < $signed(bus.data2_i))};
      default: alu_res = '0;
    endcase
  end

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            if (bus.ALUCtrl_i == OP_MUL) begin
              mcand  <= bus.data1_i;
              mplier <= bus.data2_i;
              acc    <= '0;
              cnt    <= CW'(WIDTH);
              busy_q <= 1'b1;
              state  <= MUL;
            end else begin
              data_q <= alu_res;
              done_q <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          // Final iteration publishes the sum including this cycle's partial product.
          if (cnt == CW'(1)) begin
            data_q <= acc_next;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_o = data_q;
  assign bus.zero_o = (data_q == '0);
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit (WIDTH = 32).
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] last_exp = '0;

  alu_exec_unit_if #(.WIDTH(32)) bus ();
  alu_exec_unit #(.WIDTH(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Present a request for exactly one rising edge.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.ALUCtrl_i = op;
    bus.data1_i = a;
    bus.data2_i = b;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
  endtask

  task automatic single(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    launch(op, a, b);
    @(negedge clk);
    check_eq({tag, ".data"}, bus.data_o, exp);
    check_eq({tag, ".zero"}, 32'(bus.zero_o), 32'(exp == 32'd0));
    check_eq({tag, ".done"}, 32'(bus.done_o), 32'd1);
    check_eq({tag, ".busy"}, 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    check_eq({tag, ".done_drop"}, 32'(bus.done_o), 32'd0);
    last_exp = exp;
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit interfere);
    logic busy_all = 1'b1;
    logic done_any = 1'b0;
    logic held = 1'b1;
    launch(3'b011, a, b);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      busy_all &= bus.busy_o;
      done_any |= bus.done_o;
      held &= (bus.data_o === last_exp);
      if (interfere && i == 10) begin
        bus.start_i = 1'b1;
        bus.ALUCtrl_i = 3'b010;
        bus.data1_i = 32'h0000_1111;
        bus.data2_i = 32'h0000_2222;
      end else if (interfere && i == 11) begin
        bus.start_i = 1'b0;
      end
    end
    check_eq({tag, ".busy_32"}, 32'(busy_all), 32'd1);
    check_eq({tag, ".no_early_done"}, 32'(done_any), 32'd0);
    check_eq({tag, ".held"}, 32'(held), 32'd1);
    @(negedge clk);
    check_eq({tag, ".data"}, bus.data_o, exp);
    check_eq({tag, ".zero"}, 32'(bus.zero_o), 32'(exp == 32'd0));
    check_eq({tag, ".done"}, 32'(bus.done_o), 32'd1);
    check_eq({tag, ".busy_clr"}, 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    check_eq({tag, ".done_drop"}, 32'(bus.done_o), 32'd0);
    check_eq({tag, ".data_hold"}, bus.data_o, exp);
    last_exp = exp;
  endtask

  initial begin
    logic done_seen;
    bus.start_i = 1'b0;
    bus.ALUCtrl_i = 3'b000;
    bus.data1_i = '0;
    bus.data2_i = '0;
    repeat (2) @(negedge clk);
    check_eq("rst.data", bus.data_o, 32'd0);
    check_eq("rst.zero", 32'(bus.zero_o), 32'd1);
    check_eq("rst.busy", 32'(bus.busy_o), 32'd0);
    check_eq("rst.done", 32'(bus.done_o), 32'd0);
    rst = 1'b0;

    single("add", 3'b010, 32'd3, 32'd4, 32'd7);

    // SUB followed by SLT on the very next edge.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.ALUCtrl_i = 3'b110;
    bus.data1_i = 32'd5;
    bus.data2_i = 32'd5;
    @(posedge clk);
    #1;
    bus.ALUCtrl_i = 3'b111;
    bus.data1_i = 32'hFFFF_FFFF;
    bus.data2_i = 32'd1;
    @(negedge clk);
    check_eq("sub.data", bus.data_o, 32'd0);
    check_eq("sub.zero", 32'(bus.zero_o), 32'd1);
    check_eq("sub.done", 32'(bus.done_o), 32'd1);
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    @(negedge clk);
    check_eq("slt.data", bus.data_o, 32'd1);
    check_eq("slt.zero", 32'(bus.zero_o), 32'd0);
    check_eq("slt.done", 32'(bus.done_o), 32'd1);
    @(negedge clk);
    check_eq("slt.done_drop", 32'(bus.done_o), 32'd0);
    last_exp = 32'd1;

    single("slt_ge", 3'b111, 32'd1, 32'hFFFF_FFFF, 32'd0);
    single("and", 3'b000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    single("or", 3'b001, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11);
    single("sub_wrap", 3'b110, 32'd0, 32'd1, 32'hFFFF_FFFF);
    single("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'd1);
    single("undef", 3'b100, 32'd9, 32'd9, 32'd0);
    single("add2", 3'b010, 32'd10, 32'd20, 32'd30);

    run_mul("mul7x6", 32'd7, 32'd6, 32'd42, 1'b0);
    run_mul("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_mul("mul_ovf", 32'h8000_0000, 32'd2, 32'd0, 1'b0);
    run_mul("mul3x5", 32'd3, 32'd5, 32'd15, 1'b1);

    // Reset during cycle 16 of a multiply.
    launch(3'b011, 32'd9, 32'd9);
    repeat (15) @(negedge clk);
    check_eq("abort.busy_pre", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("abort.busy", 32'(bus.busy_o), 32'd0);
    check_eq("abort.data", bus.data_o, 32'd0);
    check_eq("abort.zero", 32'(bus.zero_o), 32'd1);
    check_eq("abort.done", 32'(bus.done_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      done_seen |= bus.done_o;
    end
    check_eq("abort.no_done", 32'(done_seen), 32'd0);
    single("post_rst_add", 3'b010, 32'd2, 32'd9, 32'd11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
